// File: rtl/periph_bus_decoder_if.sv
// Transaction and target-side bus bundle for the peripheral/memory decoder.
`timescale 1ns/1ps
interface periph_bus_decoder_if #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int NUM_PERIPH = 4,
   parameter int REG_W      = 2
);
   // control-unit transaction side
   logic                         req_start_i;
   logic [ADDR_W-1:0]            req_addr_i;
   logic                         req_rnw_i;
   logic [DATA_W-1:0]            req_wdata_i;
   logic                         req_done_o;
   logic                         req_busy_o;
   logic                         req_err_o;
   logic [DATA_W-1:0]            req_rdata_o;
   // SPI memory master side
   logic                         mem_start_o;
   logic                         mem_done_i;
   logic [DATA_W-1:0]            mem_rdata_i;
   // on-chip peripheral side
   logic [NUM_PERIPH-1:0]        per_cs_o;
   logic                         per_we_o;
   logic [REG_W-1:0]             per_addr_o;
   logic [DATA_W-1:0]            per_wdata_o;
   logic [NUM_PERIPH*DATA_W-1:0] per_rdata_i;
   logic [NUM_PERIPH-1:0]        per_ready_i;

   // the decoder itself
   modport slave (
      input  req_start_i, req_addr_i, req_rnw_i, req_wdata_i,
             mem_done_i, mem_rdata_i, per_rdata_i, per_ready_i,
      output req_done_o, req_busy_o, req_err_o, req_rdata_o,
             mem_start_o, per_cs_o, per_we_o, per_addr_o, per_wdata_o
   );

   // the environment driving the decoder (control unit plus targets)
   modport master (
      output req_start_i, req_addr_i, req_rnw_i, req_wdata_i,
             mem_done_i, mem_rdata_i, per_rdata_i, per_ready_i,
      input  req_done_o, req_busy_o, req_err_o, req_rdata_o,
             mem_start_o, per_cs_o, per_we_o, per_addr_o, per_wdata_o
   );
endinterface

// File: rtl/periph_bus_decoder.sv
// Memory-map decoder/bridge: routes control-unit transactions either to the
// SPI memory master or to one of NUM_PERIPH register-mapped peripherals,
// with per-channel ready handshake, timeout and unmapped-access error.
`timescale 1ns/1ps
module periph_bus_decoder #(
   parameter int          ADDR_W      = 16,
   parameter int          DATA_W      = 8,
   parameter int          NUM_PERIPH  = 4,
   parameter int          PAGE_MSB    = 7,
   parameter logic [3:0]  PERIPH_PAGE = 4'hF,
   parameter int          REG_W       = 2,
   parameter int          SEL_W       = 2,
   parameter int          TIMEOUT     = 15
) (
   input  logic                 clk_core_i,
   input  logic                 rst_i,
   periph_bus_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      PER_WAIT = 2'd2,
      RESP     = 2'd3
   } state_t;

   localparam int                CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [SEL_W:0]    NUM_P_C   = (SEL_W + 1)'(NUM_PERIPH);

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     idx_q, idx_d;
   logic [REG_W-1:0]     reg_q, reg_d;
   logic                 we_q, we_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;

   logic [3:0]           page_s;
   logic [SEL_W-1:0]     idx_s;
   logic                 periph_s;
   logic                 mapped_s;
   logic [NUM_PERIPH-1:0] sel_mask_s;
   logic                 ready_s;
   logic [CNT_W-1:0]     cnt_inc_s;
   logic                 timeout_s;
   logic [DATA_W-1:0]    per_rdata_sel_s;
   logic                 unused_addr_s;

   // Address decode of the incoming request and channel selection of the latched one
   assign page_s        = bus.req_addr_i[PAGE_MSB -: 4];
   assign idx_s         = bus.req_addr_i[REG_W +: SEL_W];
   assign periph_s      = (page_s == PERIPH_PAGE);
   assign mapped_s      = periph_s && ({1'b0, idx_s} < NUM_P_C);
   assign sel_mask_s    = NUM_PERIPH'(1'b1) << idx_q;
   assign ready_s       = |(bus.per_ready_i & sel_mask_s);
   assign cnt_inc_s     = cnt_q + CNT_W'(1'b1);
   assign timeout_s     = (cnt_inc_s == TIMEOUT_C);
   assign unused_addr_s = ^bus.req_addr_i;

   // Read-data mux: only the latched channel contributes to the OR
   always_comb begin
      per_rdata_sel_s = {DATA_W{1'b0}};
      for (int k = 0; k < NUM_PERIPH; k++) begin
         per_rdata_sel_s = per_rdata_sel_s
                         | (bus.per_rdata_i[k*DATA_W +: DATA_W] & {DATA_W{idx_q == SEL_W'(k)}});
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_core_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= {SEL_W{1'b0}};
         reg_q   <= {REG_W{1'b0}};
         we_q    <= 1'b0;
         wdata_q <= {DATA_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         err_q   <= 1'b0;
         rdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         reg_q   <= reg_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state and capture logic; ready is tested before timeout so it wins a tie
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      reg_d   = reg_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req_start_i) begin
               we_d = ~bus.req_rnw_i;
               if (!periph_s) begin
                  state_d = MEM_WAIT;
               end else if (mapped_s) begin
                  state_d = PER_WAIT;
                  idx_d   = idx_s;
                  reg_d   = bus.req_addr_i[REG_W-1:0];
                  wdata_d = bus.req_wdata_i;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = {DATA_W{1'b0}};
               end
            end else begin
               state_d = IDLE;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_done_i) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? rdata_q : bus.mem_rdata_i;
            end else begin
               state_d = MEM_WAIT;
            end
         end
         PER_WAIT: begin
            if (ready_s) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? rdata_q : per_rdata_sel_s;
            end else if (timeout_s) begin
               state_d = RESP;
               cnt_d   = cnt_inc_s;
               err_d   = 1'b1;
               rdata_d = {DATA_W{1'b0}};
            end else begin
               cnt_d   = cnt_inc_s;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output decode; peripheral strobes are only driven while a channel is selected
   always_comb begin
      bus.req_busy_o  = (state_q != IDLE);
      bus.req_done_o  = (state_q == RESP);
      bus.req_err_o   = (state_q == RESP) && err_q;
      bus.req_rdata_o = rdata_q;
      bus.mem_start_o = (state_q == IDLE) && bus.req_start_i && !periph_s;
      if (state_q == PER_WAIT) begin
         bus.per_cs_o    = sel_mask_s;
         bus.per_we_o    = we_q;
         bus.per_addr_o  = reg_q;
         bus.per_wdata_o = wdata_q;
      end else begin
         bus.per_cs_o    = {NUM_PERIPH{1'b0}};
         bus.per_we_o    = 1'b0;
         bus.per_addr_o  = {REG_W{1'b0}};
         bus.per_wdata_o = {DATA_W{1'b0}};
      end
   end

endmodule

// File: tb/tb_periph_bus_decoder.sv
// Directed bench for periph_bus_decoder: a 4-channel instance carries the
// main sequence with a completion scoreboard, a 3-channel instance covers
// the unmapped-channel error.
`timescale 1ns/1ps
module tb_periph_bus_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks     = 0;
   int   errors     = 0;
   int   mem_starts = 0;
   int   dones      = 0;
   int   cs_cycles  = 0;

   typedef struct packed {
      logic       err;
      logic [7:0] rdata;
   } exp_t;

   exp_t sb4[$];
   exp_t exp_v;

   periph_bus_decoder_if #(.ADDR_W(16), .DATA_W(8), .NUM_PERIPH(4), .REG_W(2)) bus4 ();
   periph_bus_decoder_if #(.ADDR_W(16), .DATA_W(8), .NUM_PERIPH(3), .REG_W(2)) bus3 ();

   periph_bus_decoder #(.NUM_PERIPH(4)) u_dut4 (.clk_core_i(clk), .rst_i(rst), .bus(bus4));
   periph_bus_decoder #(.NUM_PERIPH(3)) u_dut3 (.clk_core_i(clk), .rst_i(rst), .bus(bus3));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue4(input logic [15:0] addr, input logic rnw, input logic [7:0] wd,
                         input logic exp_err, input logic [7:0] exp_rd, input bit push);
      bus4.req_start_i = 1'b1;
      bus4.req_addr_i  = addr;
      bus4.req_rnw_i   = rnw;
      bus4.req_wdata_i = wd;
      if (push) sb4.push_back({exp_err, exp_rd});
   endtask

   task automatic wait_done4(input string tag, input int exp_lat);
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 64) begin
         @(negedge clk);
         bus4.req_start_i = 1'b0;
         #1;
         lat++;
         seen = (bus4.req_done_o === 1'b1);
      end
      check(tag, 32'(lat), 32'(exp_lat));
   endtask

   // Monitor: counts strobes and pops the scoreboard on every completion
   always @(negedge clk) begin
      #1;
      if (bus4.mem_start_o === 1'b1) mem_starts++;
      if (bus4.per_cs_o !== 4'b0000) cs_cycles++;
      if (bus4.req_done_o === 1'b1) begin
         dones++;
         check("sb_has_entry", 32'(sb4.size() != 0), 32'd1);
         if (sb4.size() != 0) begin
            exp_v = sb4.pop_front();
            check("done_err", 32'(bus4.req_err_o), 32'(exp_v.err));
            check("done_rdata", 32'(bus4.req_rdata_o), 32'(exp_v.rdata));
         end
      end
   end

   initial begin
      bus4.req_start_i = 1'b0; bus4.req_addr_i = 16'h0000; bus4.req_rnw_i = 1'b0;
      bus4.req_wdata_i = 8'h00; bus4.mem_done_i = 1'b0; bus4.mem_rdata_i = 8'h00;
      bus4.per_rdata_i = 32'h0; bus4.per_ready_i = 4'h0;
      bus3.req_start_i = 1'b0; bus3.req_addr_i = 16'h0000; bus3.req_rnw_i = 1'b0;
      bus3.req_wdata_i = 8'h00; bus3.mem_done_i = 1'b0; bus3.mem_rdata_i = 8'h00;
      bus3.per_rdata_i = 24'h0; bus3.per_ready_i = 3'h0;

      // reset then idle
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("rst_idle4", 32'({bus4.req_done_o, bus4.req_busy_o, bus4.req_err_o, bus4.req_rdata_o,
                              bus4.mem_start_o, bus4.per_cs_o, bus4.per_we_o, bus4.per_addr_o,
                              bus4.per_wdata_o}), 32'd0);
      check("rst_idle3", 32'({bus3.req_done_o, bus3.req_busy_o, bus3.req_err_o, bus3.req_rdata_o,
                              bus3.mem_start_o, bus3.per_cs_o, bus3.per_we_o, bus3.per_addr_o,
                              bus3.per_wdata_o}), 32'd0);

      // zero-wait peripheral write to channel 1, register 1
      @(posedge clk); #1; cs_cycles = 0;
      bus4.per_ready_i = 4'hF;
      @(negedge clk); issue4(16'h00F5, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b1); #1;
      check("t1_mem_start", 32'(bus4.mem_start_o), 32'd0);
      check("t1_busy_idle", 32'(bus4.req_busy_o), 32'd0);
      @(negedge clk); bus4.req_start_i = 1'b0; #1;
      check("t1_cs", 32'(bus4.per_cs_o), 32'h2);
      check("t1_we_addr_wdata", 32'({bus4.per_we_o, bus4.per_addr_o, bus4.per_wdata_o}), 32'h5A5);
      check("t1_done_early", 32'(bus4.req_done_o), 32'd0);
      @(negedge clk); #1;
      check("t1_done", 32'(bus4.req_done_o), 32'd1);
      check("t1_cs_off", 32'(bus4.per_cs_o), 32'h0);
      @(posedge clk); #1;
      check("t1_cs_cycles", 32'(cs_cycles), 32'd1);

      // channel 3 read, ready after 4 cycles, other channels' ready ignored
      cs_cycles = 0;
      bus4.per_ready_i = 4'b0111;
      bus4.per_rdata_i = 32'h3C22_11C0;
      @(negedge clk); issue4(16'h00FC, 1'b1, 8'h00, 1'b0, 8'h3C, 1'b1);
      @(negedge clk); bus4.req_start_i = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk); #1;
      check("t2_cs", 32'(bus4.per_cs_o), 32'h8);
      check("t2_no_done", 32'(bus4.req_done_o), 32'd0);
      bus4.per_ready_i = 4'hF;
      @(negedge clk); bus4.per_ready_i = 4'h0; #1;
      check("t2_done", 32'(bus4.req_done_o), 32'd1);
      @(posedge clk); #1;
      check("t2_cs_cycles", 32'(cs_cycles), 32'd4);

      // memory read, stray mem_done in IDLE, second start during MEM_WAIT
      cs_cycles = 0; mem_starts = 0; dones = 0;
      @(negedge clk); bus4.mem_done_i = 1'b1; bus4.mem_rdata_i = 8'h99;
      @(negedge clk); bus4.mem_done_i = 1'b0; #1;
      check("t3_idle_memdone", 32'(bus4.req_done_o), 32'd0);
      @(negedge clk); issue4(16'h0042, 1'b1, 8'h00, 1'b0, 8'h77, 1'b1); #1;
      check("t3_mem_start", 32'(bus4.mem_start_o), 32'd1);
      @(negedge clk); bus4.req_start_i = 1'b0; #1;
      check("t3_mem_start_once", 32'(bus4.mem_start_o), 32'd0);
      check("t3_busy", 32'(bus4.req_busy_o), 32'd1);
      @(negedge clk); bus4.req_start_i = 1'b1; bus4.req_addr_i = 16'h00F0;
      @(negedge clk); bus4.req_start_i = 1'b0;
      repeat (6) @(negedge clk);
      @(negedge clk); bus4.mem_done_i = 1'b1; bus4.mem_rdata_i = 8'h77; #1;
      check("t3_not_done", 32'(bus4.req_done_o), 32'd0);
      @(negedge clk); bus4.mem_done_i = 1'b0; bus4.mem_rdata_i = 8'h00; #1;
      check("t3_done", 32'(bus4.req_done_o), 32'd1);
      @(posedge clk); #1;
      check("t3_mem_starts", 32'(mem_starts), 32'd1);
      check("t3_dones", 32'(dones), 32'd1);
      check("t3_cs_cycles", 32'(cs_cycles), 32'd0);

      // memory write keeps previous read data
      @(negedge clk); issue4(16'h0100, 1'b0, 8'h12, 1'b0, 8'h77, 1'b1);
      @(negedge clk); bus4.req_start_i = 1'b0; bus4.mem_done_i = 1'b1; bus4.mem_rdata_i = 8'h55;
      @(negedge clk); bus4.mem_done_i = 1'b0; #1;
      check("t4_done", 32'(bus4.req_done_o), 32'd1);

      // channel 0 never ready: timeout after 15 wait cycles
      bus4.per_ready_i = 4'b1110;
      @(negedge clk); issue4(16'h00F0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
      wait_done4("t5_timeout_latency", 16);

      // ready on the final wait cycle beats the timeout; start in RESP ignored
      bus4.per_ready_i = 4'b0000;
      @(negedge clk); issue4(16'h00F8, 1'b1, 8'h00, 1'b0, 8'h22, 1'b1);
      @(negedge clk); bus4.req_start_i = 1'b0;
      repeat (13) @(negedge clk);
      @(negedge clk); bus4.per_ready_i = 4'b0100; #1;
      check("t6_no_done", 32'(bus4.req_done_o), 32'd0);
      @(negedge clk); bus4.per_ready_i = 4'b0000;
      bus4.req_start_i = 1'b1; bus4.req_addr_i = 16'h0042; #1;
      check("t6_done", 32'(bus4.req_done_o), 32'd1);
      check("t6_resp_start_ignored", 32'(bus4.mem_start_o), 32'd0);
      @(negedge clk); bus4.req_start_i = 1'b0; #1;
      check("t6_idle", 32'(bus4.req_busy_o), 32'd0);

      // reset during PER_WAIT
      @(posedge clk); #1; dones = 0;
      @(negedge clk); issue4(16'h00F4, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      @(negedge clk); bus4.req_start_i = 1'b0; #1;
      check("t7_cs", 32'(bus4.per_cs_o), 32'h2);
      @(negedge clk); rst = 1'b1; #1;
      check("t7_cs_hold", 32'(bus4.per_cs_o), 32'h2);
      @(negedge clk); rst = 1'b0; #1;
      check("t7_cs_drop", 32'(bus4.per_cs_o), 32'h0);
      check("t7_busy", 32'(bus4.req_busy_o), 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      check("t7_no_done", 32'(dones), 32'd0);

      // 3-channel instance: mapped read, then unmapped channel 3
      bus3.per_ready_i = 3'b111;
      bus3.per_rdata_i = 24'h5A_0000;
      @(negedge clk); bus3.req_start_i = 1'b1; bus3.req_addr_i = 16'h00F8; bus3.req_rnw_i = 1'b1;
      @(negedge clk); bus3.req_start_i = 1'b0; #1;
      check("d3_cs", 32'(bus3.per_cs_o), 32'h4);
      @(negedge clk); #1;
      check("d3_read", 32'({bus3.req_done_o, bus3.req_err_o, bus3.req_rdata_o}), 32'h25A);
      @(negedge clk); bus3.req_start_i = 1'b1; bus3.req_addr_i = 16'h00FC; #1;
      check("d3_no_mem_start", 32'(bus3.mem_start_o), 32'd0);
      @(negedge clk); bus3.req_start_i = 1'b0; #1;
      check("d3_unmapped", 32'({bus3.req_done_o, bus3.req_err_o, bus3.req_rdata_o, bus3.per_cs_o}),
            32'h1800);
      @(negedge clk); #1;
      check("d3_after", 32'({bus3.req_done_o, bus3.req_err_o, bus3.req_busy_o, bus3.req_rdata_o}),
            32'h0);

      @(posedge clk); #1;
      check("sb_drained", 32'(sb4.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/periph_bus_decoder.md
Name: periph_bus_decoder

Overview:
- Parametrised memory-map decoder and bridge between the control unit's transaction interface and its targets: the external SPI memory master and NUM_PERIPH on-chip peripherals.
- Replaces fixed single-peripheral gating with N decoded channels, per-channel ready handshake, read-back data, a timeout and an unmapped-access error.
- Sits between control_unit and spi_master / ps_pwm_wrapper-class peripherals.

Parameters:
- ADDR_W, 16: request address width.
- DATA_W, 8: data width.
- NUM_PERIPH, 4: peripheral channel count, 1..16.
- PAGE_MSB, 7: MSB of page-compare field; the field is addr[PAGE_MSB:PAGE_MSB-3].
- PERIPH_PAGE, 4'hF: page value selecting the peripheral window.
- REG_W, 2: register-offset bits per peripheral, addr[REG_W-1:0].
- SEL_W, 2: channel-select bits, addr[REG_W+SEL_W-1:REG_W]; 2^SEL_W >= NUM_PERIPH.
- TIMEOUT, 15: max PER_WAIT cycles before an error completion, >=1.

Ports:
- clk_core_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- req_start_i  in  1  transaction start pulse from control unit
- req_addr_i  in  ADDR_W  transaction address
- req_rnw_i  in  1  1=read, 0=write
- req_wdata_i  in  DATA_W  write data
- req_done_o  out  1  one-cycle completion pulse
- req_busy_o  out  1  transaction in flight
- req_err_o  out  1  error flag, valid with req_done_o
- req_rdata_o  out  DATA_W  read data, valid with req_done_o and held until next done
- mem_start_o  out  1  start to SPI master
- mem_done_i  in  1  SPI master done
- mem_rdata_i  in  DATA_W  SPI read byte1
- per_cs_o  out  NUM_PERIPH  one-hot channel select
- per_we_o  out  1  write enable
- per_addr_o  out  REG_W  register offset
- per_wdata_o  out  DATA_W  write data
- per_rdata_i  in  NUM_PERIPH*DATA_W  channel k read data at [k*DATA_W +: DATA_W]
- per_ready_i  in  NUM_PERIPH  channel k access complete

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, req_rdata_o 0. Reset has priority over every other event, including mid-transaction: the bridge returns to IDLE with no done pulse and per_cs_o drops the next cycle.
- FSM states are IDLE, MEM_WAIT, PER_WAIT and RESP.
- Decode: periph = (addr[PAGE_MSB:PAGE_MSB-3] == PERIPH_PAGE); idx = select field; mapped = periph && idx < NUM_PERIPH.
- IDLE accepts req_start_i.
  - Non-periph address: mem_start_o = 1 combinationally in the same cycle, next state MEM_WAIT.
  - Mapped periph: latch idx, addr[REG_W-1:0], !rnw and wdata; next state PER_WAIT.
  - Unmapped periph: next state RESP with err=1 and rdata=0.
- mem_start_o is asserted only in that IDLE-accept cycle.
- MEM_WAIT: on mem_done_i, capture mem_rdata_i (reads only; writes keep the previous rdata) with err=0, and go to RESP.
- PER_WAIT:
  - per_cs_o[idx] = 1 for the whole state.
  - per_we_o, per_addr_o and per_wdata_o are driven from the latched values and stay stable.
  - On per_ready_i[idx]: capture the channel rdata (reads), err=0, go to RESP. Ready bits of other channels are ignored.
  - The counter increments on each PER_WAIT cycle without ready. When it reaches TIMEOUT with no ready, go to RESP with err=1 and rdata=0.
  - If ready and timeout coincide in the same cycle, ready wins (err=0).
- RESP: req_done_o = 1 for exactly one cycle, req_err_o valid in the same cycle, counter cleared, return to IDLE.
  - req_err_o returns to 0 after the pulse.
  - req_rdata_o holds until the next RESP.
- req_busy_o = 1 in MEM_WAIT, PER_WAIT and RESP; 0 in IDLE.
- req_start_i outside IDLE is ignored and no second transaction is queued. A new start is accepted in the cycle after the done pulse.
- Latency for a zero-wait peripheral (ready tied high), start at cycle 0: cs high at cycle 1, done at cycle 2.
- Latency for an unmapped access: done at cycle 1.
- Latency for memory: done one cycle after mem_done_i.
- mem_done_i pulses outside MEM_WAIT are ignored.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; assert rst_i during PER_WAIT -> per_cs_o drops the next cycle, no req_done_o.
- Write addr 0x00F5, data 0xA5, per_ready_i all 1 -> per_cs_o = 4'b0010 for 1 cycle with per_addr_o = 1, per_we_o = 1, per_wdata_o = 0xA5; req_done_o at cycle 2, err = 0.
- Read addr 0x00FC, channel 3 rdata 0x3C, ready after 4 cycles -> cs3 high 4 cycles; req_rdata_o = 0x3C and req_done_o one cycle after ready.
- Read addr 0x0042, mem_done_i 10 cycles later with mem_rdata_i = 0x77 -> mem_start_o pulses at cycle 0 only; req_rdata_o = 0x77; per_cs_o stays 0.
- NUM_PERIPH = 3: read 0x00FC -> done at cycle 1, err = 1, rdata = 0. Also, channel 0 never ready -> done after TIMEOUT = 15 wait cycles with err = 1.
- req_start_i pulsed again during MEM_WAIT -> ignored, exactly one mem_start_o and one done; ready coinciding with timeout -> err = 0.
